register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 122 ++++++++++++
 tb/tb_register_file.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: multi-entry register file with one write port and two
// independent registered read ports (1-cycle read latency).
// Optional feature macro: REGISTER_FILE_BYPASS_EN
//   defined   -> a read of the address being written in the same cycle
//                returns the new write data (write-first)
//   undefined -> such a read returns the entry's pre-write value (read-first)
// Reset is synchronous and active-low; addresses >= REG_COUNT are ignored
// for writes and read back as zero.
module register_file #(
  parameter int                   BIT_WIDTH   = 32,
  parameter int                   REG_COUNT   = 16,
  parameter logic [BIT_WIDTH-1:0] RESET_VALUE = '0,
  localparam int                  ADDR_W      = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [BIT_WIDTH-1:0] wr_data,
  input  logic                 rd0_en,
  input  logic [ADDR_W-1:0]    rd0_addr,
  output logic [BIT_WIDTH-1:0] rd0_data,
  output logic                 rd0_valid,
  input  logic                 rd1_en,
  input  logic [ADDR_W-1:0]    rd1_addr,
  output logic [BIT_WIDTH-1:0] rd1_data,
  output logic                 rd1_valid
);

  // Entry count expressed at address width + 1 so the range compare is exact.
  localparam logic [ADDR_W:0] COUNT_W = REG_COUNT[ADDR_W:0];

  // True when the address selects an implemented entry.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < COUNT_W);
  endfunction

  logic [BIT_WIDTH-1:0] mem_q [REG_COUNT];
  logic [BIT_WIDTH-1:0] mem_d [REG_COUNT];

  logic [BIT_WIDTH-1:0] rd0_data_q, rd0_data_d;
  logic [BIT_WIDTH-1:0] rd1_data_q, rd1_data_d;
  logic                 rd0_valid_q, rd0_valid_d;
  logic                 rd1_valid_q, rd1_valid_d;

  logic                 wr_hit_s;
  logic [BIT_WIDTH-1:0] rd0_mem_s, rd1_mem_s;
  logic [BIT_WIDTH-1:0] rd0_sel_s, rd1_sel_s;

  // A write only lands when it targets an implemented entry.
  assign wr_hit_s = wr_en & in_range(wr_addr);

  // Stored value seen by each read port; unimplemented addresses read as zero.
  assign rd0_mem_s = in_range(rd0_addr) ? mem_q[rd0_addr] : {BIT_WIDTH{1'b0}};
  assign rd1_mem_s = in_range(rd1_addr) ? mem_q[rd1_addr] : {BIT_WIDTH{1'b0}};

`ifdef REGISTER_FILE_BYPASS_EN
  // Write-first: forward the in-flight write data on a same-address read.
  assign rd0_sel_s = (wr_hit_s && (rd0_addr == wr_addr)) ? wr_data : rd0_mem_s;
  assign rd1_sel_s = (wr_hit_s && (rd1_addr == wr_addr)) ? wr_data : rd1_mem_s;
`else
  // Read-first: a same-address read sees the value before this cycle's write.
  assign rd0_sel_s = rd0_mem_s;
  assign rd1_sel_s = rd1_mem_s;
`endif

  // Next-state for the storage array and both read ports.
  always_comb begin
    mem_d       = mem_q;
    rd0_data_d  = rd0_data_q;
    rd0_valid_d = 1'b0;
    rd1_data_d  = rd1_data_q;
    rd1_valid_d = 1'b0;

    if (wr_hit_s) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d = mem_q;
    end

    if (rd0_en) begin
      rd0_data_d  = rd0_sel_s;
      rd0_valid_d = 1'b1;
    end else begin
      rd0_data_d  = rd0_data_q;
      rd0_valid_d = 1'b0;
    end

    if (rd1_en) begin
      rd1_data_d  = rd1_sel_s;
      rd1_valid_d = 1'b1;
    end else begin
      rd1_data_d  = rd1_data_q;
      rd1_valid_d = 1'b0;
    end
  end

  // State registers; synchronous reset wins over any write or read request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= RESET_VALUE;
      end
      rd0_data_q  <= {BIT_WIDTH{1'b0}};
      rd0_valid_q <= 1'b0;
      rd1_data_q  <= {BIT_WIDTH{1'b0}};
      rd1_valid_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      rd0_data_q  <= rd0_data_d;
      rd0_valid_q <= rd0_valid_d;
      rd1_data_q  <= rd1_data_d;
      rd1_valid_q <= rd1_valid_d;
    end
  end

  assign rd0_data  = rd0_data_q;
  assign rd0_valid = rd0_valid_q;
  assign rd1_data  = rd1_data_q;
  assign rd1_valid = rd1_valid_q;

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed + short random stimulus against two instances of
// register_file (default 16 entries, and 12 entries for out-of-range cases).
// Expectations come from a behavioural model and travel through a scoreboard
// queue. Build with +define+REGISTER_FILE_BYPASS_EN to check write-first mode.
module tb_register_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;

  // Instance 0: REG_COUNT = 16
  logic        a_wr_en = 1'b0, a_rd0_en = 1'b0, a_rd1_en = 1'b0;
  logic [3:0]  a_wr_addr = 4'd0, a_rd0_addr = 4'd0, a_rd1_addr = 4'd0;
  logic [31:0] a_wr_data = 32'd0;
  logic [31:0] a_rd0_data, a_rd1_data;
  logic        a_rd0_valid, a_rd1_valid;

  // Instance 1: REG_COUNT = 12
  logic        b_wr_en = 1'b0, b_rd0_en = 1'b0, b_rd1_en = 1'b0;
  logic [3:0]  b_wr_addr = 4'd0, b_rd0_addr = 4'd0, b_rd1_addr = 4'd0;
  logic [31:0] b_wr_data = 32'd0;
  logic [31:0] b_rd0_data, b_rd1_data;
  logic        b_rd0_valid, b_rd1_valid;

  register_file u_dut16 (
    .clk(clk), .reset(reset),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .rd0_en(a_rd0_en), .rd0_addr(a_rd0_addr), .rd0_data(a_rd0_data), .rd0_valid(a_rd0_valid),
    .rd1_en(a_rd1_en), .rd1_addr(a_rd1_addr), .rd1_data(a_rd1_data), .rd1_valid(a_rd1_valid)
  );

  register_file #(.REG_COUNT(12)) u_dut12 (
    .clk(clk), .reset(reset),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd0_en(b_rd0_en), .rd0_addr(b_rd0_addr), .rd0_data(b_rd0_data), .rd0_valid(b_rd0_valid),
    .rd1_en(b_rd1_en), .rd1_addr(b_rd1_addr), .rd1_data(b_rd1_data), .rd1_valid(b_rd1_valid)
  );

  typedef struct {
    int          inst;
    string       tag;
    logic [31:0] d0;
    logic        v0;
    logic [31:0] d1;
    logic        v1;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem [2][16];
  logic [31:0] m_d0 [2];
  logic [31:0] m_d1 [2];
  int          n_assert = 0;
  int          n_fail   = 0;

  function automatic int entry_count(input int inst);
    return (inst == 0) ? 16 : 12;
  endfunction

  // Reference read value: zero when out of range, write data on a bypass hit.
  function automatic logic [31:0] model_rd(input int inst, input logic [3:0] ra,
                                           input logic we, input logic [3:0] wa,
                                           input logic [31:0] wd);
    if (int'(ra) >= entry_count(inst)) return 32'd0;
`ifdef REGISTER_FILE_BYPASS_EN
    if (we && (wa == ra)) return wd;
`endif
    return m_mem[inst][ra];
  endfunction

  task automatic chk(input string tag, input int k, input string what,
                     input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s inst%0d %s observed=0x%0h expected=0x%0h", tag, k, what, obs, exp_v);
    end
  endtask

  // One clock of stimulus on instance 'inst' (the other sits idle), with
  // expected outputs of both instances pushed before the edge and checked after.
  task automatic step(input int inst, input logic rst_n,
                      input logic we, input logic [3:0] wa, input logic [31:0] wd,
                      input logic r0e, input logic [3:0] r0a,
                      input logic r1e, input logic [3:0] r1a,
                      input string tag);
    exp_t e;
    logic kwe, kr0e, kr1e;
    for (int k = 0; k < 2; k++) begin
      kwe  = (k == inst) ? we  : 1'b0;
      kr0e = (k == inst) ? r0e : 1'b0;
      kr1e = (k == inst) ? r1e : 1'b0;
      e.inst = k;
      e.tag  = tag;
      if (!rst_n) begin
        e.d0 = 32'd0; e.v0 = 1'b0; e.d1 = 32'd0; e.v1 = 1'b0;
        for (int j = 0; j < 16; j++) m_mem[k][j] = 32'd0;
      end else begin
        e.v0 = kr0e;
        e.d0 = kr0e ? model_rd(k, r0a, kwe, wa, wd) : m_d0[k];
        e.v1 = kr1e;
        e.d1 = kr1e ? model_rd(k, r1a, kwe, wa, wd) : m_d1[k];
        if (kwe && (int'(wa) < entry_count(k))) m_mem[k][wa] = wd;
      end
      m_d0[k] = e.d0;
      m_d1[k] = e.d1;
      sb_q.push_back(e);
    end

    reset      = rst_n;
    a_wr_en    = (inst == 0) ? we  : 1'b0;
    a_rd0_en   = (inst == 0) ? r0e : 1'b0;
    a_rd1_en   = (inst == 0) ? r1e : 1'b0;
    b_wr_en    = (inst == 1) ? we  : 1'b0;
    b_rd0_en   = (inst == 1) ? r0e : 1'b0;
    b_rd1_en   = (inst == 1) ? r1e : 1'b0;
    a_wr_addr  = wa;  a_wr_data = wd;  a_rd0_addr = r0a; a_rd1_addr = r1a;
    b_wr_addr  = wa;  b_wr_data = wd;  b_rd0_addr = r0a; b_rd1_addr = r1a;

    @(posedge clk);
    #1;

    for (int k = 0; k < 2; k++) begin
      e = sb_q.pop_front();
      chk(e.tag, e.inst, "rd0_data",  (e.inst == 0) ? a_rd0_data  : b_rd0_data,  e.d0);
      chk(e.tag, e.inst, "rd0_valid", {31'd0, (e.inst == 0) ? a_rd0_valid : b_rd0_valid}, {31'd0, e.v0});
      chk(e.tag, e.inst, "rd1_data",  (e.inst == 0) ? a_rd1_data  : b_rd1_data,  e.d1);
      chk(e.tag, e.inst, "rd1_valid", {31'd0, (e.inst == 0) ? a_rd1_valid : b_rd1_valid}, {31'd0, e.v1});
    end

    reset = 1'b1;
  endtask

  initial begin
    logic [3:0] ra, rb, wa;

    // Reset state, then every entry reads back as the reset value on both ports
    step(0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, "reset");
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i);
      step(0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, ra, 1'b1, ra, "reset_readback");
    end

    // Write then read, then read port idle holds data and drops valid
    step(0, 1'b1, 1'b1, 4'd3, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, "wr_addr3");
    step(0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, "rd_addr3");
    step(0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd3, 1'b0, 4'd0, "rd_idle_hold");

    // Same-cycle write and read of one address
    step(0, 1'b1, 1'b1, 4'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, "wr5_7");
    step(0, 1'b1, 1'b1, 4'd5, 32'd8, 1'b0, 4'd0, 1'b1, 4'd5, "collision");
    step(0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd5, "after_collision");

    // Dual read of different addresses alongside an unrelated write
    step(0, 1'b1, 1'b1, 4'd2, 32'hA, 1'b0, 4'd0, 1'b0, 4'd0, "wr2");
    step(0, 1'b1, 1'b1, 4'd4, 32'hB, 1'b0, 4'd0, 1'b0, 4'd0, "wr4");
    step(0, 1'b1, 1'b1, 4'd6, 32'hC, 1'b1, 4'd2, 1'b1, 4'd4, "dual_read_with_wr");
    step(0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd6, 1'b1, 4'd6, "same_addr_both_ports");

    // Back-to-back writes to one address, read in the following cycle
    step(0, 1'b1, 1'b1, 4'd9, 32'h1, 1'b0, 4'd0, 1'b0, 4'd0, "b2b_1");
    step(0, 1'b1, 1'b1, 4'd9, 32'h2, 1'b0, 4'd0, 1'b0, 4'd0, "b2b_2");
    step(0, 1'b1, 1'b1, 4'd9, 32'h3, 1'b0, 4'd0, 1'b0, 4'd0, "b2b_3");
    step(0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd9, 1'b0, 4'd0, "b2b_read");

    // Short random traffic on the 16-entry instance
    for (int i = 0; i < 40; i++) begin
      wa = 4'($urandom_range(15, 0));
      ra = ($urandom_range(3, 0) == 0) ? wa : 4'($urandom_range(15, 0));
      rb = ($urandom_range(3, 0) == 0) ? wa : 4'($urandom_range(15, 0));
      step(0, 1'b1, 1'($urandom_range(1, 0)), wa, $urandom(),
           1'($urandom_range(1, 0)), ra, 1'($urandom_range(1, 0)), rb, "random");
    end

    // Reset priority over a same-cycle write and read
    step(0, 1'b1, 1'b1, 4'd1, 32'h11, 1'b1, 4'd1, 1'b0, 4'd0, "pre_reset_wr1");
    step(0, 1'b0, 1'b1, 4'd1, 32'hFF, 1'b1, 4'd1, 1'b1, 4'd3, "reset_priority");
    step(0, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 1'b1, 4'd3, "post_reset_read");

    // Out-of-range addresses on the 12-entry instance
    step(1, 1'b1, 1'b1, 4'd13, 32'h55, 1'b0, 4'd0, 1'b0, 4'd0, "oor_wr13");
    step(1, 1'b1, 1'b1, 4'd12, 32'h55, 1'b0, 4'd0, 1'b0, 4'd0, "oor_wr12");
    step(1, 1'b1, 1'b1, 4'd11, 32'h66, 1'b1, 4'd13, 1'b1, 4'd12, "oor_read");
    for (int i = 0; i < 12; i++) begin
      ra = 4'(i);
      step(1, 1'b1, 1'b0, 4'd0, 32'd0, 1'b1, ra, 1'b1, 4'd15, "oor_no_change");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
